// File: rtl/qdec_pkg.sv
// Shared constants and step-classification helper for the quadrature decoder.
// Build option QDEC_FILTER_EN (see qdec_pin_sync) does not affect this package.
package qdec_pkg;

   // Gray-coded pin states {a,b}, in forward rotation order
   localparam logic [1:0] ST_00 = 2'b00;
   localparam logic [1:0] ST_01 = 2'b01;
   localparam logic [1:0] ST_11 = 2'b11;
   localparam logic [1:0] ST_10 = 2'b10;

   localparam logic DIR_FWD = 1'b1;
   localparam logic DIR_BWD = 1'b0;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_FWD  = 2'd1,
      STEP_BWD  = 2'd2,
      STEP_ERR  = 2'd3
   } step_e;

   // State that follows st when the shaft turns one step forward
   function automatic logic [1:0] fwd_next(input logic [1:0] st);
      logic [1:0] nxt;
      case (st)
         ST_00:   nxt = ST_01;
         ST_01:   nxt = ST_11;
         ST_11:   nxt = ST_10;
         default: nxt = ST_00;
      endcase
      return nxt;
   endfunction

   // Classify the move from prev to cur
   function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
      step_e res;
      if (prev == cur)
         res = STEP_NONE;
      else if ((prev ^ cur) == 2'b11)
         res = STEP_ERR;
      else if (fwd_next(prev) == cur)
         res = STEP_FWD;
      else
         res = STEP_BWD;
      return res;
   endfunction

endpackage

// File: rtl/qdec_pin_sync.sv
// Per-pin front end: 2-flop synchroniser for an asynchronous encoder pin.
// With QDEC_FILTER_EN defined, a deglitch filter follows the synchroniser: its
// output only moves after the input has held a new value for FILTER_LEN clks.
module qdec_pin_sync #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin,
   output logic pin_sync
);

   logic [1:0] sync_q;

   // Two-stage metastability synchroniser
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      if (!reset_n)
         sync_q <= 2'b00;
      else
         sync_q <= {sync_q[0], pin};
   end

`ifdef QDEC_FILTER_EN
   logic [3:0] stable_cnt;
   logic       filt_q;

   // Count consecutive samples that disagree with the output; adopt the new value after FILTER_LEN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_cnt <= 4'd0;
         filt_q     <= 1'b0;
      end else if (sync_q[1] != filt_q) begin
         if (stable_cnt == 4'(FILTER_LEN - 1)) begin
            filt_q     <= sync_q[1];
            stable_cnt <= 4'd0;
         end else begin
            stable_cnt <= stable_cnt + 4'd1;
         end
      end else begin
         stable_cnt <= 4'd0;
      end
   end

   assign pin_sync = filt_q;
`else
   localparam int unused_filter_len = FILTER_LEN;

   assign pin_sync = sync_q[1];
`endif

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: A/B pins -> signed position, direction, step period,
// stall and illegal-transition flags. Define QDEC_FILTER_EN to insert the
// per-pin deglitch filter (adds FILTER_LEN clks of latency).
module quadrature_decoder
   import qdec_pkg::*;
#(
   parameter int                    DATA_WIDTH = 16,
   parameter logic [DATA_WIDTH-1:0] TIMEOUT    = 16'hFFFF,
   parameter int                    FILTER_LEN = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  encoder_a,
   input  logic                  encoder_b,
   input  logic                  clear,
   input  logic                  error_clr,
   output logic [DATA_WIDTH-1:0] position,
   output logic                  direction,
   output logic                  step_valid,
   output logic [DATA_WIDTH-1:0] period,
   output logic                  period_valid,
   output logic                  stalled,
   output logic                  quad_error
);

   localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   logic                  a_s, b_s;
   logic [1:0]            cur_st, prev_st;
   logic [1:0]            prime_cnt;
   logic                  primed;
   step_e                 step;
   logic                  is_step;
   logic [DATA_WIDTH-1:0] cnt, cnt_next;

   qdec_pin_sync #(.FILTER_LEN(FILTER_LEN)) u_sync_a (
      .clk      (clk),
      .reset_n  (reset_n),
      .pin      (encoder_a),
      .pin_sync (a_s)
   );

   qdec_pin_sync #(.FILTER_LEN(FILTER_LEN)) u_sync_b (
      .clk      (clk),
      .reset_n  (reset_n),
      .pin      (encoder_b),
      .pin_sync (b_s)
   );

   assign cur_st = {a_s, b_s};
   // Reset values in the synchroniser take three edges to be replaced by the
   // real pin state in prev_st, so decoding waits until the counter reaches 3.
   assign primed = (prime_cnt == 2'd3);

   // Priming counter and previous-state register (prev_st follows cur_st every clk)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prime_cnt <= 2'd0;
         prev_st   <= ST_00;
      end else begin
         prev_st <= cur_st;
         if (!primed)
            prime_cnt <= prime_cnt + 2'd1;
      end
   end

   // Transition classification
   always_comb begin
      // NOTE: default first so every path assigns step and no latch is inferred.
      step = STEP_NONE;
      if (primed)
         step = decode_step(prev_st, cur_st);
   end

   assign is_step  = (step == STEP_FWD) || (step == STEP_BWD);
   assign cnt_next = (cnt == TIMEOUT) ? cnt : cnt + ONE;

   // Position, direction and step pulse; clear overrides the position update
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         position   <= '0;
         direction  <= DIR_BWD;
         step_valid <= 1'b0;
      end else begin
         step_valid <= is_step;
         if (is_step)
            direction <= (step == STEP_FWD) ? DIR_FWD : DIR_BWD;
         if (clear)
            position <= '0;
         else if (step == STEP_FWD)
            position <= position + ONE;
         else if (step == STEP_BWD)
            position <= position - ONE;
      end
   end

   // Step-period measurement and stall detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt          <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         stalled      <= 1'b1;
      end else begin
         period_valid <= 1'b0;
         if (is_step) begin
            if (!stalled) begin
               period       <= cnt + ONE;
               period_valid <= 1'b1;
            end
            stalled <= 1'b0;
            cnt     <= '0;
         end else begin
            cnt <= cnt_next;
            if (cnt_next == TIMEOUT)
               stalled <= 1'b1;
         end
      end
   end

   // Sticky illegal-transition flag; a new error beats error_clr
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         quad_error <= 1'b0;
      else if (step == STEP_ERR)
         quad_error <= 1'b1;
      else if (error_clr)
         quad_error <= 1'b0;
   end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder: directed pin sequences, a
// behavioural model compared every cycle, and literal spot checks.
// Define QDEC_FILTER_EN for both bench and RTL to exercise the deglitch filter.
module tb_quadrature_decoder;

   localparam int TIMEOUT_C = 100;
   localparam int FL        = 3;
`ifdef QDEC_FILTER_EN
   localparam int LAT = 3 + FL;
`else
   localparam int LAT = 3;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        encoder_a = 1'b0, encoder_b = 1'b0;
   logic        clear = 1'b0, error_clr = 1'b0;
   logic [15:0] position, period;
   logic        direction, step_valid, period_valid, stalled, quad_error;

   int checks = 0;
   int passes = 0;
   int sv_seen = 0;
   int pv_seen = 0;

   quadrature_decoder #(
      .DATA_WIDTH (16),
      .TIMEOUT    (16'd100),
      .FILTER_LEN (FL)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .encoder_a    (encoder_a),
      .encoder_b    (encoder_b),
      .clear        (clear),
      .error_clr    (error_clr),
      .position     (position),
      .direction    (direction),
      .step_valid   (step_valid),
      .period       (period),
      .period_valid (period_valid),
      .stalled      (stalled),
      .quad_error   (quad_error)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp)
         passes++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Position of a pin state around the forward cycle 00,01,11,10
   function automatic int gidx(input logic [1:0] s);
      case (s)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   int          m_edges;
   logic [1:0]  p1, p2;       // pins sampled one and two edges ago
   logic [1:0]  d1, d2;       // decoder-visible state one and two edges ago
   logic [1:0]  win [0:14];   // recent synchronised samples (filter window)
   logic [1:0]  f;            // filtered state
   logic [15:0] m_pos, m_per;
   int          m_cnt;
   logic        m_dir, m_sv, m_pv, m_stall, m_err;

   task automatic model_reset();
      m_edges = 0;
      p1 = 2'b00; p2 = 2'b00; d1 = 2'b00; d2 = 2'b00; f = 2'b00;
      for (int i = 0; i < 15; i++) win[i] = 2'b00;
      m_pos = 16'h0; m_per = 16'h0; m_cnt = 0;
      m_dir = 1'b0; m_sv = 1'b0; m_pv = 1'b0; m_stall = 1'b1; m_err = 1'b0;
   endtask

   task automatic model_edge(input logic [1:0] pins, input logic clr, input logic eclr);
      int   diff;
      logic stp, fwd, bad;
      logic [1:0] dnew;
      if (m_edges < 10) m_edges++;
      stp = 1'b0; fwd = 1'b0; bad = 1'b0;
      if (m_edges >= 4 && d1 != d2) begin
         diff = (gidx(d1) + 4 - gidx(d2)) % 4;
         if (diff == 1)      begin stp = 1'b1; fwd = 1'b1; end
         else if (diff == 3) stp = 1'b1;
         else                bad = 1'b1;
      end
      m_sv = stp;
      m_pv = 1'b0;
      if (stp) begin
         m_pos = clr ? 16'h0 : (fwd ? m_pos + 16'h1 : m_pos - 16'h1);
         m_dir = fwd;
         if (!m_stall) begin
            m_per = 16'(m_cnt + 1);
            m_pv  = 1'b1;
         end
         m_stall = 1'b0;
         m_cnt   = 0;
      end else begin
         if (clr) m_pos = 16'h0;
         if (m_cnt < TIMEOUT_C) m_cnt++;
         if (m_cnt == TIMEOUT_C) m_stall = 1'b1;
      end
      if (bad) m_err = 1'b1;
      else if (eclr) m_err = 1'b0;
`ifdef QDEC_FILTER_EN
      for (int i = FL - 1; i > 0; i--) win[i] = win[i-1];
      win[0] = p2;
      for (int b = 0; b < 2; b++) begin
         logic same;
         same = 1'b1;
         for (int i = 1; i < FL; i++) if (win[i][b] != win[0][b]) same = 1'b0;
         if (same) f[b] = win[0][b];
      end
      dnew = f;
`else
      dnew = p1;
`endif
      d2 = d1; d1 = dnew; p2 = p1; p1 = pins;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else model_edge({encoder_a, encoder_b}, clear, error_clr);
      end
   end

   // Per-cycle comparison against the model
   initial forever begin
      @(posedge clk);
      #1;
      check("position", position, m_pos);
      check("direction", direction, m_dir);
      check("step_valid", step_valid, m_sv);
      check("period", period, m_per);
      check("period_valid", period_valid, m_pv);
      check("stalled", stalled, m_stall);
      check("quad_error", quad_error, m_err);
      if (step_valid) sv_seen++;
      if (period_valid) pv_seen++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_pins(input logic [1:0] v);
      @(negedge clk);
      {encoder_a, encoder_b} = v;
   endtask

   task automatic hold(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic step_to(input logic [1:0] v, input int hold_n);
      set_pins(v);
      hold(hold_n - 1);
   endtask

   task automatic expect_latency(input logic [1:0] v, input string name);
      set_pins(v);
      repeat (LAT - 1) begin
         @(posedge clk); #1;
         check({name, " early"}, step_valid, 1'b0);
      end
      @(posedge clk); #1;
      check(name, step_valid, 1'b1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      hold(3);
      check("reset position", position, 16'h0);
      check("reset stalled", stalled, 1'b1);
      check("reset quad_error", quad_error, 1'b0);
      check("reset period", period, 16'h0);
      check("reset direction", direction, 1'b0);

      // Forward run, 22 clks per state
      reset_n = 1'b1;
      sv_seen = 0; pv_seen = 0;
      hold(4);
      expect_latency(2'b01, "fwd latency");
      hold(22 - LAT);
      step_to(2'b11, 22);
      step_to(2'b10, 22);
      step_to(2'b00, 8);
      check("fwd position", position, 16'd4);
      check("fwd direction", direction, 1'b1);
      check("fwd step pulses", sv_seen, 4);
      check("fwd period pulses", pv_seen, 3);
      check("fwd period", period, 16'd22);

      // Clear alone
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      check("clear position", position, 16'h0);

      // Backward with wrap
      step_to(2'b10, 8);
      check("bwd wrap position", position, 16'hFFFF);
      check("bwd direction", direction, 1'b0);
      step_to(2'b11, 8);
      check("bwd position 2", position, 16'hFFFE);
      step_to(2'b01, 8);
      step_to(2'b00, 8);
      check("bwd position 4", position, 16'hFFFC);

      // Illegal jump 00 -> 11
      sv_seen = 0;
      step_to(2'b11, 8);
      check("illegal flag", quad_error, 1'b1);
      check("illegal position", position, 16'hFFFC);
      check("illegal no step", sv_seen, 0);
      @(negedge clk); error_clr = 1'b1;
      @(negedge clk); error_clr = 1'b0;
      check("error_clr", quad_error, 1'b0);

      // New illegal transition in the error_clr cycle: set wins
      set_pins(2'b00);
      repeat (LAT - 1) @(negedge clk);
      error_clr = 1'b1;
      @(posedge clk); #1;
      check("error set beats clr", quad_error, 1'b1);
      @(negedge clk); error_clr = 1'b0;
      hold(4);
      check("error sticky", quad_error, 1'b1);
      @(negedge clk); error_clr = 1'b1;
      @(negedge clk); error_clr = 1'b0;

      // Stall after TIMEOUT clks without a step
      set_pins(2'b01);
      repeat (LAT) @(posedge clk);
      #1;
      check("stall lead step", step_valid, 1'b1);
      repeat (TIMEOUT_C - 1) @(posedge clk);
      #1;
      check("stall not yet", stalled, 1'b0);
      @(posedge clk); #1;
      check("stall asserted", stalled, 1'b1);
      hold(10);
      set_pins(2'b11);
      repeat (LAT) @(posedge clk);
      #1;
      check("post-stall step", step_valid, 1'b1);
      check("post-stall no period", period_valid, 1'b0);
      check("post-stall stalled", stalled, 1'b0);
      check("post-stall position", position, 16'hFFFE);

      // Clear collides with a forward step
      set_pins(2'b10);
      repeat (LAT - 1) @(negedge clk);
      clear = 1'b1;
      @(posedge clk); #1;
      check("collide step", step_valid, 1'b1);
      check("collide position", position, 16'h0);
      check("collide direction", direction, 1'b1);
      @(negedge clk); clear = 1'b0;

      // Reset mid-operation with pins resting at 11
      set_pins(2'b11);
      hold(1);
      reset_n = 1'b0;
      #1;
      check("async reset position", position, 16'h0);
      hold(3);
      reset_n = 1'b1;
      sv_seen = 0;
      hold(10);
`ifndef QDEC_FILTER_EN
      check("release at 11 error", quad_error, 1'b0);
      check("release at 11 steps", sv_seen, 0);
`endif
      check("release position", position, 16'h0);
      expect_latency(2'b10, "post-reset latency");
      check("post-reset position", position, 16'd1);

`ifdef QDEC_FILTER_EN
      // Glitch shorter than FILTER_LEN is ignored; a stable change steps
      @(negedge clk);
      {encoder_a, encoder_b} = 2'b00;
      reset_n = 1'b0;
      hold(3);
      reset_n = 1'b1;
      hold(12);
      sv_seen = 0;
      set_pins(2'b10);
      hold(1);
      set_pins(2'b00);
      hold(12);
      check("glitch no step", sv_seen, 0);
      check("glitch position", position, 16'h0);
      expect_latency(2'b10, "filter latency");
      check("filter position", position, 16'd1);
`endif

      hold(5);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
